mem_bus_arbiter: RTL and testbench

- Shares the single RAM/IO memory port between the instruction-fetch master and the data load/store master.
- Sequences each access: grant, region decode, write strobe, wait states, then response.
- Sits between the core's two bus ports and the RAM/IO read-data mux and write-enable logic.
- Region decode uses address bits [31:28]; the external read-data mux is replaced by an internal registered capture.

---
 rtl/mem_bus_arbiter_if.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two core masters, the arbiter and the RAM/IO port.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] rd_ram_dat;
    logic [31:0] rd_io_dat;
    logic        ram_wr;
    logic        io_wr;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, rd_ram_dat, rd_io_dat,
        output if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_wdata, ram_wr, io_wr, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, rd_ram_dat, rd_io_dat,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_wdata, ram_wr, io_wr, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared RAM/IO port: alternating grant on contention,
// region decode on addr[31:28], IO wait states and registered read-data capture.
//
// state  | meaning
// IDLE   | no transaction; grant a pending request
// ACCESS | one cycle with address on the bus; write strobe for writes
// WAIT   | IO wait states, counter counts down to 1
// RESP   | one-cycle ack to the granted master
module mem_bus_arbiter #(
    parameter logic [3:0]  RAM_ADDR = 4'h2,
    parameter logic [3:0]  IO_ADDR  = 4'h4,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] IO_WAIT_C = 4'(IO_WAIT);

    state_t      state_q, state_d;
    logic        gnt_data_q, gnt_data_d;
    logic        last_data_q, last_data_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [3:0]  region;
    logic        is_ram;
    logic        is_io;
    logic [31:0] rd_sel;
    logic        pick_data;
    logic        capture;

    assign region = mem_addr_q[31:28];
    assign is_ram = (region == RAM_ADDR);
    assign is_io  = (region == IO_ADDR);
    assign rd_sel = is_ram ? bus.rd_ram_dat : (is_io ? bus.rd_io_dat : 32'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        capture     = 1'b0;
        // On a tie the master that did not win last time goes first.
        pick_data   = bus.d_req && (!bus.if_req || !last_data_q);

        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    mem_addr_d  = pick_data ? bus.d_addr : bus.if_addr;
                    mem_wdata_d = pick_data ? bus.d_wdata : 32'h0;
                    we_d        = pick_data && bus.d_we;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = is_io ? IO_WAIT_C : 4'd0;
                if (is_io && (IO_WAIT_C != 4'd0)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture && !we_q) begin
            if (gnt_data_q) d_rdata_d  = rd_sel;
            else            if_rdata_d = rd_sel;
        end
    end

    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.ram_wr    = (state_q == S_ACCESS) && we_q && is_ram;
        bus.io_wr     = (state_q == S_ACCESS) && we_q && is_io;
        bus.d_ack     = (state_q == S_RESP) && gnt_data_q;
        bus.if_ack    = (state_q == S_RESP) && !gnt_data_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.if_rdata  = if_rdata_q;
        bus.d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam logic [3:0] RAM_R = 4'h2;
    localparam logic [3:0] IO_R  = 4'h4;
    localparam int         IO_W  = 2;

    logic clk;
    logic rst;
    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.RAM_ADDR(RAM_R), .IO_ADDR(IO_R), .IO_WAIT(IO_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a);
        return (a[31:28] == IO_R) ? 2 + IO_W : 2;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [31:0] ramv,
                                           input logic [31:0] iov);
        if (a[31:28] == RAM_R) return ramv;
        if (a[31:28] == IO_R)  return iov;
        return 32'h0;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},      32'(bus.busy),   32'h0);
        chk({tag, ".if_ack"},    32'(bus.if_ack), 32'h0);
        chk({tag, ".d_ack"},     32'(bus.d_ack),  32'h0);
        chk({tag, ".ram_wr"},    32'(bus.ram_wr), 32'h0);
        chk({tag, ".io_wr"},     32'(bus.io_wr),  32'h0);
        chk({tag, ".if_rdata"},  bus.if_rdata,    32'h0);
        chk({tag, ".d_rdata"},   bus.d_rdata,     32'h0);
        chk({tag, ".mem_addr"},  bus.mem_addr,    32'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,   32'h0);
    endtask

    // One transaction from an idle bus; request is driven at a falling edge (cycle N = 0).
    task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] ramv,
                       input logic [31:0] iov, input string tag);
        int lat;
        int ack_c;
        bit w;
        logic [3:0] rg;
        w     = is_d && we;
        rg    = addr[31:28];
        lat   = exp_lat(addr);
        ack_c = 0;
        bus.rd_ram_dat = ramv;
        bus.rd_io_dat  = iov;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int c = 1; c <= lat + 4 && ack_c == 0; c++) begin
            @(negedge clk);
            chk({tag, ".busy"},   32'(bus.busy), 32'h1);
            chk({tag, ".ram_wr"}, 32'(bus.ram_wr), 32'(c == 1 && w && rg == RAM_R));
            chk({tag, ".io_wr"},  32'(bus.io_wr),  32'(c == 1 && w && rg == IO_R));
            chk({tag, ".other_ack"}, 32'(is_d ? bus.if_ack : bus.d_ack), 32'h0);
            if (c == 1) begin
                chk({tag, ".mem_addr"}, bus.mem_addr, addr);
                if (w) chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
            end
            if ((is_d ? bus.d_ack : bus.if_ack) === 1'b1) ack_c = c;
        end
        chk({tag, ".ack_cycle"}, 32'(ack_c), 32'(lat));
        if (!w) begin
            if (is_d) m_d_rdata  = exp_rd(addr, ramv, iov);
            else      m_if_rdata = exp_rd(addr, ramv, iov);
        end
        chk({tag, ".d_rdata"},  bus.d_rdata,  m_d_rdata);
        chk({tag, ".if_rdata"}, bus.if_rdata, m_if_rdata);
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, ".idle_ack"},  32'(bus.if_ack | bus.d_ack), 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  rg;
        bit          is_d;
        bit          we;

        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.rd_ram_dat = 32'h0; bus.rd_io_dat = 32'h0;
        m_if_rdata = 32'h0;
        m_d_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 1'b0, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0, "ram_rd");
        txn(1'b1, 1'b1, 32'h4000_0004, 32'h0000_00A5, 32'h0, 32'h0, "io_wr");

        // Contention straight out of reset: data first, then strict alternation.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_if_rdata = 32'h0;
        m_d_rdata  = 32'h0;
        r = $urandom;
        bus.rd_ram_dat = r;
        bus.if_req = 1'b1; bus.if_addr = 32'h2000_0100;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h2000_0200;
        for (int c = 1; c <= 12; c++) begin
            bit ack_slot;
            bit data_turn;
            @(negedge clk);
            ack_slot  = (c >= 2) && ((c - 2) % 3 == 0) && (c <= 11);
            data_turn = (((c - 2) / 3) % 2) == 0;
            chk("tie.d_ack",  32'(bus.d_ack),  32'(ack_slot && data_turn));
            chk("tie.if_ack", 32'(bus.if_ack), 32'(ack_slot && !data_turn));
            if (c == 11) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
        end
        m_if_rdata = r;
        m_d_rdata  = r;
        chk("tie.d_rdata",  bus.d_rdata,  m_d_rdata);
        chk("tie.if_rdata", bus.if_rdata, m_if_rdata);
        chk("tie.busy",     32'(bus.busy), 32'h0);

        txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h1234_5678, 32'hCAFE_0000, "unmapped");

        // Reset in the middle of an IO write's wait states.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4000_0004; bus.d_wdata = 32'h0000_005A;
        repeat (2) @(negedge clk);
        chk("abort.busy_before", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        m_if_rdata = 32'h0;
        m_d_rdata  = 32'h0;
        chk_zero("abort.immediate");
        bus.d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort.d_ack", 32'(bus.d_ack), 32'h0);
            chk("abort.io_wr", 32'(bus.io_wr), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        txn(1'b1, 1'b1, 32'h4000_0004, 32'h0000_005A, 32'h0, 32'h0, "abort.retry");

        txn(1'b0, 1'b0, 32'h2000_0040, 32'h0, 32'h1111_1111, 32'hFFFF_FFFF, "hold.if_ram");
        txn(1'b1, 1'b0, 32'h4000_0008, 32'h0, 32'h3333_3333, 32'h2222_2222, "hold.d_io");
        chk("hold.if_rdata", bus.if_rdata, 32'h1111_1111);

        for (int i = 0; i < 40; i++) begin
            is_d = 1'($urandom % 2);
            we   = is_d && 1'($urandom % 2);
            case ($urandom % 4)
                0:       rg = RAM_R;
                1:       rg = IO_R;
                2:       rg = 4'h8;
                default: rg = 4'h0;
            endcase
            txn(is_d, we, {rg, 28'($urandom)}, $urandom, $urandom, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
